eighty_twos_mem_responder: RTL and testbench

- Memory-side target for the Eighty_Twos CPU's breakout bus. It decodes the CPU's address, store-enable and read-enable pins, and serves bytes from an internal instruction ROM and data RAM. It drives the returned byte and the data/instruction select back to the CPU.
- It also owns a byte-wide ROM programming port. While programming, it holds the CPU deselected (cpu_cs low).

---
 rtl/eighty_twos_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_eighty_twos_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eighty_twos_mem_responder.sv
// Memory-side target for the Eighty_Twos breakout bus: instruction ROM with a
// byte-wide programming port, data RAM, and a fixed-latency read return path.
module eighty_twos_mem_responder #(
    parameter int unsigned ROM_DEPTH    = 256,
    parameter int unsigned RAM_DEPTH    = 256,
    parameter logic [15:0] RAM_BASE     = 16'h8000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_store_en,
    input  logic        bus_read_en,
    output logic [7:0]  bus_rdata,
    output logic        bus_data_sel,
    output logic        cpu_cs,
    input  logic        prog_en,
    input  logic        prog_wen,
    input  logic [7:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic        bus_err
);

    localparam int unsigned ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned LAST   = READ_LATENCY - 1;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        cpu_cs_q;
    logic [7:0]  rdata_q;
    logic        sel_q;
    logic        err_q;

    logic [7:0]  rom_q [ROM_DEPTH];
    logic [7:0]  ram_q [RAM_DEPTH];

    logic [READ_LATENCY-1:0] pv_q;
    logic [READ_LATENCY-1:0] ps_q;
    logic [READ_LATENCY-1:0] pe_q;
    logic [7:0]              pd_q [READ_LATENCY];

    logic              active_c;
    logic              flush_c;
    logic              store_c;
    logic              read_c;
    logic              rom_hit_c;
    logic              ram_hit_c;
    logic [31:0]       addr_w_c;
    logic [ROM_AW-1:0] rom_idx_c;
    logic [RAM_AW-1:0] ram_idx_c;
    logic [7:0]        rd_data_c;
    logic              rd_sel_c;
    logic              rd_err_c;

    // Next-state logic: LOAD while programming is requested, RUN otherwise
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (!prog_en) state_d = ST_RUN;
            ST_RUN:  if (prog_en)  state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    // Bus qualification, address decode and read-data selection at sample time
    always_comb begin
        active_c  = (state_q == ST_RUN) && !prog_en;
        flush_c   = (state_q == ST_RUN) && prog_en;
        store_c   = active_c && bus_store_en;
        read_c    = active_c && bus_read_en && !bus_store_en;
        addr_w_c  = 32'(bus_addr);
        rom_hit_c = addr_w_c < ROM_DEPTH;
        ram_hit_c = (addr_w_c >= 32'(RAM_BASE)) && (addr_w_c < (32'(RAM_BASE) + RAM_DEPTH));
        rom_idx_c = ROM_AW'(bus_addr);
        ram_idx_c = RAM_AW'(bus_addr - RAM_BASE);
        rd_data_c = 8'h00;
        rd_sel_c  = 1'b1;
        rd_err_c  = 1'b0;
        if (rom_hit_c) begin
            rd_data_c = rom_q[rom_idx_c];
            rd_sel_c  = 1'b0;
        end else if (ram_hit_c) begin
            rd_data_c = ram_q[ram_idx_c];
        end else begin
            rd_err_c  = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    // ROM programming port, active only in LOAD
    always_ff @(posedge clk) begin
        if ((state_q == ST_LOAD) && prog_wen && (32'(prog_addr) < ROM_DEPTH))
            rom_q[ROM_AW'(prog_addr)] <= prog_data;
    end

    // Data RAM store port; reads use the array directly so a store is visible next edge
    always_ff @(posedge clk) begin
        if (store_c && ram_hit_c)
            ram_q[ram_idx_c] <= bus_wdata;
    end

    // Read-return pipeline carrying the sampled result for READ_LATENCY edges
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pv_q <= '0;
            ps_q <= '0;
            pe_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) pd_q[i] <= 8'h00;
        end else if (flush_c) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= read_c;
            pd_q[0] <= rd_data_c;
            ps_q[0] <= rd_sel_c;
            pe_q[0] <= rd_err_c;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
                ps_q[i] <= ps_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    // Registered bus outputs; a returning read result overrides a same-edge store's select
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpu_cs_q <= 1'b0;
            rdata_q  <= 8'h00;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= 1'b0;
            cpu_cs_q <= (state_d == ST_RUN);
            if (!flush_c) begin
                if (store_c) begin
                    sel_q <= 1'b1;
                    if (!ram_hit_c) err_q <= 1'b1;
                end
                if (pv_q[LAST]) begin
                    rdata_q <= pd_q[LAST];
                    sel_q   <= ps_q[LAST];
                    if (pe_q[LAST]) err_q <= 1'b1;
                end
            end
        end
    end

    assign bus_rdata    = rdata_q;
    assign bus_data_sel = sel_q;
    assign cpu_cs       = cpu_cs_q;
    assign bus_err      = err_q;

endmodule

// File: tb/tb_eighty_twos_mem_responder.sv
// Bench for eighty_twos_mem_responder: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based behavioural model.
module tb_eighty_twos_mem_responder;

    localparam int unsigned ROM_DEPTH = 256;
    localparam int unsigned RAM_DEPTH = 256;
    localparam int unsigned LAT       = 1;
    localparam int unsigned RAM_BASE  = 32'h8000;

    logic        clk;
    logic        nrst;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_store_en;
    logic        bus_read_en;
    logic [7:0]  bus_rdata;
    logic        bus_data_sel;
    logic        cpu_cs;
    logic        prog_en;
    logic        prog_wen;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    eighty_twos_mem_responder #(
        .ROM_DEPTH(ROM_DEPTH), .RAM_DEPTH(RAM_DEPTH),
        .RAM_BASE(16'h8000), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .nrst(nrst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_store_en(bus_store_en), .bus_read_en(bus_read_en),
        .bus_rdata(bus_rdata), .bus_data_sel(bus_data_sel), .cpu_cs(cpu_cs),
        .prog_en(prog_en), .prog_wen(prog_wen),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory arrays plus a queue of reads tagged with their due edge
    typedef struct {
        int         due;
        logic [7:0] data;
        logic       sel;
        logic       err;
    } rd_t;

    logic [7:0] m_rom [ROM_DEPTH];
    logic [7:0] m_ram [RAM_DEPTH];
    rd_t        pend[$];
    bit         m_run;
    logic       m_cs, m_sel, m_err;
    logic [7:0] m_rdata;
    int         cyc = 0;

    function automatic bit in_ram(input logic [15:0] a);
        return (int'(a) >= int'(RAM_BASE)) && (int'(a) < int'(RAM_BASE + RAM_DEPTH));
    endfunction

    // Model update on each edge, then compare against the DUT just after it
    always @(posedge clk) begin
        rd_t r;
        int  a;
        if (!nrst) begin
            m_run = 0; m_cs = 0; m_rdata = 8'h00; m_sel = 0; m_err = 0;
            pend.delete();
        end else begin
            m_err = 0;
            if (!m_run) begin
                if (prog_wen && int'(prog_addr) < int'(ROM_DEPTH)) m_rom[prog_addr] = prog_data;
                if (!prog_en) m_run = 1;
            end else if (prog_en) begin
                pend.delete();
                m_run = 0;
            end else begin
                a = int'(bus_addr);
                if (bus_store_en) begin
                    m_sel = 1;
                    if (in_ram(bus_addr)) m_ram[a - int'(RAM_BASE)] = bus_wdata;
                    else m_err = 1;
                end else if (bus_read_en) begin
                    r.due = cyc + int'(LAT);
                    if (a < int'(ROM_DEPTH)) begin
                        r.data = m_rom[a]; r.sel = 0; r.err = 0;
                    end else if (in_ram(bus_addr)) begin
                        r.data = m_ram[a - int'(RAM_BASE)]; r.sel = 1; r.err = 0;
                    end else begin
                        r.data = 8'h00; r.sel = 1; r.err = 1;
                    end
                    pend.push_back(r);
                end
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    r = pend.pop_front();
                    m_rdata = r.data;
                    m_sel   = r.sel;
                    if (r.err) m_err = 1;
                end
            end
            m_cs = m_run;
            cyc++;
        end
        #1;
        chk("model_cs",    16'(cpu_cs),       16'(m_cs));
        chk("model_rdata", 16'(bus_rdata),    16'(m_rdata));
        chk("model_sel",   16'(bus_data_sel), 16'(m_sel));
        chk("model_err",   16'(bus_err),      16'(m_err));
    end

    // Drive one bus request for exactly one edge, starting and ending at a negedge
    task automatic bus(input logic st, input logic rd, input logic [15:0] a, input logic [7:0] w);
        bus_store_en = st; bus_read_en = rd; bus_addr = a; bus_wdata = w;
        @(negedge clk);
        bus_store_en = 0; bus_read_en = 0;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        prog_wen = 1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_wen = 0;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(5))
            0: return 16'($urandom_range(255));
            1: return 16'h8000 + 16'($urandom_range(255));
            2: return 16'h80FF;
            3: return 16'h8100;
            4: return ($urandom_range(1) != 0) ? 16'h00FF : 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [7:0] rom_init [5];

    initial begin
        rom_init[0] = 8'h3E; rom_init[1] = 8'h55; rom_init[2] = 8'h76;
        rom_init[3] = 8'hC3; rom_init[4] = 8'h44;
        nrst = 0; prog_en = 1; prog_wen = 0; prog_addr = 0; prog_data = 0;
        bus_addr = 0; bus_wdata = 0; bus_store_en = 0; bus_read_en = 0;
        @(negedge clk); @(negedge clk);
        chk("reset_rdata", 16'(bus_rdata), 16'h0000);
        chk("reset_cs",    16'(cpu_cs),    16'h0000);
        nrst = 1;
        @(negedge clk);

        // Program the full ROM while held in LOAD
        for (int i = 0; i < int'(ROM_DEPTH); i++)
            prog(8'(i), (i < 5) ? rom_init[i] : 8'($urandom));
        chk("load_cs_low", 16'(cpu_cs), 16'h0000);
        prog_en = 0;
        @(negedge clk);
        chk("run_cs", 16'(cpu_cs), 16'h0001);

        // Pipelined instruction fetches
        bus(0, 1, 16'h0000, 8'h00);
        bus(0, 1, 16'h0001, 8'h00);
        chk("fetch0", 16'(bus_rdata), 16'h003E);
        chk("fetch0_sel", 16'(bus_data_sel), 16'h0000);
        bus(0, 1, 16'h0002, 8'h00);
        chk("fetch1", 16'(bus_rdata), 16'h0055);
        bus(0, 0, 16'h0000, 8'h00);
        chk("fetch2", 16'(bus_rdata), 16'h0076);

        // Fill RAM so every later read has a known value
        for (int i = 0; i < int'(RAM_DEPTH); i++)
            bus(1, 0, 16'h8000 + 16'(i), 8'($urandom));

        // Store then immediate load
        bus(1, 0, 16'h8010, 8'hA5);
        bus(0, 1, 16'h8010, 8'h00);
        bus(0, 0, 16'h0000, 8'h00);
        chk("ram_load", 16'(bus_rdata), 16'h00A5);
        chk("ram_load_sel", 16'(bus_data_sel), 16'h0001);
        chk("ram_load_err", 16'(bus_err), 16'h0000);

        // Store into ROM window is rejected
        bus(1, 0, 16'h0004, 8'h12);
        chk("rom_store_err", 16'(bus_err), 16'h0001);
        bus(0, 1, 16'h0004, 8'h00);
        bus(0, 0, 16'h0000, 8'h00);
        chk("rom4_intact", 16'(bus_rdata), 16'h0044);

        // Unmapped read just past the RAM window
        bus(0, 1, 16'h8100, 8'h00);
        bus(0, 0, 16'h0000, 8'h00);
        chk("unmapped_data", 16'(bus_rdata), 16'h0000);
        chk("unmapped_err",  16'(bus_err),   16'h0001);

        // Store and read together: store wins at the top RAM byte
        bus(1, 1, 16'h80FF, 8'h7E);
        chk("simul_err", 16'(bus_err), 16'h0000);
        bus(0, 0, 16'h0000, 8'h00);
        chk("simul_noread", 16'(bus_rdata), 16'h0000);
        bus(0, 1, 16'h80FF, 8'h00);
        bus(0, 0, 16'h0000, 8'h00);
        chk("top_ram", 16'(bus_rdata), 16'h007E);
        bus(0, 1, 16'h8100, 8'h00);
        bus(0, 0, 16'h0000, 8'h00);
        chk("past_top_err", 16'(bus_err), 16'h0001);

        // Re-program with a read in flight: result is dropped, rdata holds
        bus(0, 1, 16'h8010, 8'h00);
        bus(0, 1, 16'h0000, 8'h00);
        chk("pre_prog_rdata", 16'(bus_rdata), 16'h00A5);
        prog_en = 1;
        @(negedge clk);
        chk("reprog_cs",    16'(cpu_cs),    16'h0000);
        chk("reprog_hold",  16'(bus_rdata), 16'h00A5);
        chk("reprog_noerr", 16'(bus_err),   16'h0000);
        @(negedge clk);
        chk("reprog_hold2", 16'(bus_rdata), 16'h00A5);

        // Reset mid-run with a read in flight; ROM survives
        prog_en = 0;
        @(negedge clk);
        bus(0, 1, 16'h8010, 8'h00);
        bus(0, 1, 16'h0000, 8'h00);
        nrst = 0;
        #1;
        chk("arst_rdata", 16'(bus_rdata),    16'h0000);
        chk("arst_cs",    16'(cpu_cs),       16'h0000);
        chk("arst_sel",   16'(bus_data_sel), 16'h0000);
        chk("arst_err",   16'(bus_err),      16'h0000);
        @(negedge clk);
        nrst = 1;
        @(negedge clk);
        chk("rerun_cs", 16'(cpu_cs), 16'h0001);
        bus(0, 1, 16'h0003, 8'h00);
        bus(0, 0, 16'h0000, 8'h00);
        chk("rom3_survives", 16'(bus_rdata), 16'h00C3);

        // Randomized traffic including programming windows
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(99));
            if (prog_en) begin
                if (r < 20) prog_en = 0;
            end else begin
                if (r < 3) prog_en = 1;
            end
            prog_wen     = ($urandom_range(1) != 0);
            prog_addr    = 8'($urandom);
            prog_data    = 8'($urandom);
            bus_addr     = pick_addr();
            bus_wdata    = 8'($urandom);
            bus_store_en = ($urandom_range(3) == 0);
            bus_read_en  = ($urandom_range(1) != 0);
            @(negedge clk);
        end
        bus_store_en = 0; bus_read_en = 0; prog_wen = 0; prog_en = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
